uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_fifo.sv | 73 +++++++
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, idle line level, transmitter
// state encoding and the parity helper. The PARITY state and the parity
// helper exist only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DataWidth = 8;
  localparam logic IdleLevel = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DataWidth-1:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_fifo.sv
// Single-clock synchronous FIFO with push/pop and an occupancy count.
// Pointers wrap naturally because Depth is a power of two; full and empty
// come from the count so there is no pointer-equality ambiguity.
module uart_fifo #(
  parameter int Depth = 16,
  parameter int Width = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [Width-1:0]        din,
  output logic [Width-1:0]        dout,
  output logic [$clog2(Depth):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PtrW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Advance pointers on accepted operations; a push and pop together keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO. Frames are start, 8 data bits
// LSB-first, optional even parity (define UART_TX_PARITY_EN), then
// StopBits stop bits. Line changes happen only on bit_clk edges, and a
// queued byte follows the last stop bit with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int Depth    = 16,
  parameter int StopBits = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic [DataWidth-1:0]    din,
  input  logic                    wr,
  output logic                    full,
  output logic [$clog2(Depth):0]  count,
  output logic                    ovf,
  output logic                    txd,
  output logic                    busy
);

  localparam int IdxW = $clog2(DataWidth);

  tx_state_e            state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 txd_q, txd_d;
  logic                 ovf_q, ovf_d;
  logic                 pop;
  logic [DataWidth-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  uart_fifo #(
    .Depth (Depth),
    .Width (DataWidth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign full = fifo_full;
  assign ovf  = ovf_q;
  assign txd  = txd_q;
  assign busy = (state_q != IDLE) || !fifo_empty;

  // Frame sequencing: every transition and line change is gated by bit_clk.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    ovf_d      = wr && fifo_full;
    if (bit_clk) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_dout;
            txd_d   = 1'b0;
            state_d = START;
          end
        end
        START: begin
          txd_d     = data_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_idx_q == IdxW'(DataWidth - 1)) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = even_parity(data_q);
            state_d = PARITY;
`else
            txd_d      = IdleLevel;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
            txd_d     = data_q[bit_idx_d];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          txd_d      = IdleLevel;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
`endif
        STOP: begin
          if (stop_cnt_q == 1'(StopBits - 1)) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              data_d  = fifo_dout;
              txd_d   = 1'b0;
              state_d = START;
            end else begin
              txd_d   = IdleLevel;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          txd_d   = IdleLevel;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers; reset truncates any frame and returns the line to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= IdleLevel;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset state, single and back-to-back
// frames, overflow, mid-frame reset, write latency, push+pop in one cycle,
// two stop bits, and parity frames when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_clk;
  logic       wr, wr2;
  logic [7:0] din, din2;
  logic       full, ovf, txd, busy;
  logic       full2, ovf2, txd2, busy2;
  logic [4:0] count, count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.Depth(16), .StopBits(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .bit_clk (bit_clk),
    .din     (din),
    .wr      (wr),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .txd     (txd),
    .busy    (busy)
  );

  uart_tx_fifo #(.Depth(16), .StopBits(2)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .bit_clk (bit_clk),
    .din     (din2),
    .wr      (wr2),
    .full    (full2),
    .count   (count2),
    .ovf     (ovf2),
    .txd     (txd2),
    .busy    (busy2)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    repeat (7) tick();
    bit_clk = 1'b1;
    tick();
    bit_clk = 1'b0;
  endtask

  task automatic write_byte(input bit sel, input logic [7:0] b);
    if (sel) begin
      din2 = b;
      wr2  = 1'b1;
    end else begin
      din = b;
      wr  = 1'b1;
    end
    tick();
    wr  = 1'b0;
    wr2 = 1'b0;
  endtask

  function automatic logic line(input bit sel);
    return sel ? txd2 : txd;
  endfunction

  task automatic expect_bits(input bit sel, input logic [7:0] b, input string name);
    for (int i = 0; i < 8; i++) begin
      pulse();
      check($sformatf("%s_bit%0d", name, i), line(sel), b[i]);
    end
`ifdef UART_TX_PARITY_EN
    pulse();
    check($sformatf("%s_parity", name), line(sel), ^b);
`endif
    pulse();
    check($sformatf("%s_stop", name), line(sel), 1'b1);
  endtask

  initial begin
    reset   = 1'b1;
    bit_clk = 1'b0;
    wr      = 1'b0;
    wr2     = 1'b0;
    din     = 8'h00;
    din2    = 8'h00;
    repeat (3) tick();
    check("rst_txd", txd, 1'b1);
    check("rst_count", count, 5'd0);
    check("rst_full", full, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // single byte 0x55
    write_byte(1'b0, 8'h55);
    check("single_count", count, 5'd1);
    check("single_busy", busy, 1'b1);
    check("single_idle_before", txd, 1'b1);
    pulse();
    check("single_start", txd, 1'b0);
    check("single_popped", count, 5'd0);
    expect_bits(1'b0, 8'h55, "single");
    check("single_busy_stop", busy, 1'b1);
    pulse();
    check("single_end_txd", txd, 1'b1);
    check("single_end_busy", busy, 1'b0);

    // back-to-back 0xA5 then 0x3C
    write_byte(1'b0, 8'hA5);
    write_byte(1'b0, 8'h3C);
    check("b2b_count", count, 5'd2);
    pulse();
    check("b2b_start1", txd, 1'b0);
    check("b2b_count1", count, 5'd1);
    expect_bits(1'b0, 8'hA5, "b2b_a5");
    pulse();
    check("b2b_start2", txd, 1'b0);
    check("b2b_count2", count, 5'd0);
    expect_bits(1'b0, 8'h3C, "b2b_3c");
    pulse();
    check("b2b_end_txd", txd, 1'b1);
    check("b2b_end_busy", busy, 1'b0);

    // push during the popping bit_clk edge: count stays, byte queues
    write_byte(1'b0, 8'h81);
    repeat (7) tick();
    bit_clk = 1'b1;
    wr      = 1'b1;
    din     = 8'h5A;
    tick();
    bit_clk = 1'b0;
    wr      = 1'b0;
    check("pushpop_count", count, 5'd1);
    check("pushpop_start", txd, 1'b0);
    expect_bits(1'b0, 8'h81, "pushpop_81");
    pulse();
    check("pushpop_start2", txd, 1'b0);
    expect_bits(1'b0, 8'h5A, "pushpop_5a");
    pulse();
    check("pushpop_end_busy", busy, 1'b0);

    // overflow: 16 writes fill, 17th is dropped
    for (int i = 0; i < 16; i++) begin
      write_byte(1'b0, 8'(i * 17));
    end
    check("ovf_count16", count, 5'd16);
    check("ovf_full", full, 1'b1);
    check("ovf_quiet", ovf, 1'b0);
    write_byte(1'b0, 8'hEE);
    check("ovf_pulse", ovf, 1'b1);
    check("ovf_count_kept", count, 5'd16);
    check("ovf_full_kept", full, 1'b1);
    tick();
    check("ovf_pulse_end", ovf, 1'b0);

    // oldest byte (0x00) comes out; reset during its data bit 3
    pulse();
    check("mid_start", txd, 1'b0);
    check("mid_count", count, 5'd15);
    check("mid_full", full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      check($sformatf("mid_bit%0d", i), txd, 1'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_count", count, 5'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_full", full, 1'b0);
    tick();

    // write on the same edge as bit_clk: start waits for the next bit_clk
    din     = 8'hC3;
    wr      = 1'b1;
    bit_clk = 1'b1;
    tick();
    wr      = 1'b0;
    bit_clk = 1'b0;
    check("lat_txd", txd, 1'b1);
    check("lat_count", count, 5'd1);
    pulse();
    check("lat_start", txd, 1'b0);
    expect_bits(1'b0, 8'hC3, "post_rst");
    pulse();
    check("post_rst_end_busy", busy, 1'b0);

`ifdef UART_TX_PARITY_EN
    // parity frames: 0x07 has three ones, 0x03 has two
    write_byte(1'b0, 8'h07);
    pulse();
    check("par07_start", txd, 1'b0);
    expect_bits(1'b0, 8'h07, "par07");
    pulse();
    write_byte(1'b0, 8'h03);
    pulse();
    check("par03_start", txd, 1'b0);
    expect_bits(1'b0, 8'h03, "par03");
    pulse();
    check("par_end_busy", busy, 1'b0);
`endif

    // two stop bits: 0xFF then 0x00 on the StopBits=2 instance
    write_byte(1'b1, 8'hFF);
    write_byte(1'b1, 8'h00);
    check("sb2_count", count2, 5'd2);
    pulse();
    check("sb2_start1", txd2, 1'b0);
    expect_bits(1'b1, 8'hFF, "sb2_ff");
    pulse();
    check("sb2_stop2", txd2, 1'b1);
    check("sb2_busy_stop2", busy2, 1'b1);
    pulse();
    check("sb2_start2", txd2, 1'b0);
    expect_bits(1'b1, 8'h00, "sb2_00");
    pulse();
    check("sb2_stop2b", txd2, 1'b1);
    check("sb2_busy_stop2b", busy2, 1'b1);
    pulse();
    check("sb2_end_txd", txd2, 1'b1);
    check("sb2_end_busy", busy2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
